// File: rtl/control_signals_pkg.sv
// Shared encodings for the single-cycle MIPS main decoder: control bus layout,
// selector enums, opcode/funct codes and the reference 9-bit control words.
package control_signals;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned WORD_W   = 9;
  localparam int unsigned ALU_W    = 3;

  typedef enum logic [1:0] {
    WA_RT  = 2'b00,
    WA_RD  = 2'b01,
    WA_R31 = 2'b10
  } sel_wa_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_DMEM = 2'b01,
    RES_PC4  = 2'b10
  } sel_result_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RS     = 2'b11
  } sel_pc_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // Coarse ALU request from the main decoder; FUNCT defers to the funct field.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic        rf_we;
    sel_wa_e     sel_wa;
    logic        sel_alu_b;
    logic        dmem_we;
    sel_result_e sel_result;
    sel_pc_e     sel_pc;
    alu_ctrl_e   alu_ctrl;
  } ControlBus;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] F_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

  // {rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc}
  localparam logic [WORD_W-1:0] NOPc   = 9'b0_00_0_0_00_00;
  localparam logic [WORD_W-1:0] LWc    = 9'b1_00_1_0_01_00;
  localparam logic [WORD_W-1:0] SWc    = 9'b0_00_1_1_00_00;
  localparam logic [WORD_W-1:0] ADDIc  = 9'b1_00_1_0_00_00;
  localparam logic [WORD_W-1:0] Jc     = 9'b0_00_0_0_00_10;
  localparam logic [WORD_W-1:0] JALc   = 9'b1_10_0_0_10_10;
  localparam logic [WORD_W-1:0] BEQNc  = 9'b0_00_0_0_00_00;
  localparam logic [WORD_W-1:0] BEQYc  = 9'b0_00_0_0_00_01;
  localparam logic [WORD_W-1:0] RTYPEc = 9'b1_01_0_0_00_00;
  localparam logic [WORD_W-1:0] JRc    = 9'b0_00_0_0_00_11;

  function automatic ControlBus make_bus(input logic [WORD_W-1:0] word,
                                         input alu_ctrl_e alu);
    return ControlBus'({word, alu});
  endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU decoder: turns the coarse ALU request plus R-type funct into alu_ctrl,
// and flags whether funct is one of the supported arithmetic/logic codes.
module alu_decoder
  import control_signals::*;
(
  input  logic [FUNCT_W-1:0] funct_i,
  input  alu_op_e            alu_op_i,
  output alu_ctrl_e          alu_ctrl_o,
  output logic               funct_ok_o
);

  alu_ctrl_e funct_ctrl_c;

  always_comb begin
    funct_ok_o   = 1'b1;
    funct_ctrl_c = ALU_ADD;
    case (funct_i)
      F_ADD:   funct_ctrl_c = ALU_ADD;
      F_SUB:   funct_ctrl_c = ALU_SUB;
      F_AND:   funct_ctrl_c = ALU_AND;
      F_OR:    funct_ctrl_c = ALU_OR;
      F_SLT:   funct_ctrl_c = ALU_SLT;
      default: funct_ok_o   = 1'b0;
    endcase

    case (alu_op_i)
      ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: alu_ctrl_o = funct_ctrl_c;
      default:     alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder of the single-cycle MIPS core: combinational control bus from
// {opcode, funct, zero}, plus a sticky flag recording any unsupported decode.
module control_unit
  import control_signals::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output ControlBus           control_bus,
  output logic                illegal_op
);

  logic [WORD_W-1:0] word_c;
  alu_op_e           alu_op_c;
  alu_ctrl_e         alu_ctrl_c;
  logic              funct_ok_c;
  logic              illegal_c;
  logic              illegal_d;
  logic              illegal_q;

  alu_decoder u_alu_decoder (
    .funct_i   (funct),
    .alu_op_i  (alu_op_c),
    .alu_ctrl_o(alu_ctrl_c),
    .funct_ok_o(funct_ok_c)
  );

  // Unsupported encodings fall through as a NOP with PC+4 and no writes.
  always_comb begin
    word_c    = NOPc;
    alu_op_c  = ALUOP_ADD;
    illegal_c = 1'b0;
    case (opcode)
      OP_LW:   word_c = LWc;
      OP_SW:   word_c = SWc;
      OP_ADDI: word_c = ADDIc;
      OP_J:    word_c = Jc;
      OP_JAL:  word_c = JALc;
      OP_BEQ: begin
        word_c   = zero ? BEQYc : BEQNc;
        alu_op_c = ALUOP_SUB;
      end
      OP_RTYPE: begin
        if (funct == F_JR) begin
          word_c = JRc;
        end else if (funct_ok_c) begin
          word_c   = RTYPEc;
          alu_op_c = ALUOP_FUNCT;
        end else begin
          illegal_c = 1'b1;
        end
      end
      default: illegal_c = 1'b1;
    endcase
  end

  assign control_bus = make_bus(word_c, alu_ctrl_c);

  assign illegal_d = illegal_q | illegal_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares against the DUT.
module tb_control_unit;

  logic                      clock;
  logic                      reset_n;
  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic                      zero;
  control_signals::ControlBus control_bus;
  logic                      illegal_op;

  typedef struct {
    string      name;
    logic [8:0] word;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

  control_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .control_bus(control_bus),
    .illegal_op (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are settled half a cycle after each vector is driven.
  initial begin
    exp_t        e;
    logic [11:0] bits;
    forever begin
      @(negedge clock);
      if (sb_q.size() != 0) begin
        e    = sb_q.pop_front();
        bits = control_bus;
        check({e.name, ".word"}, 12'(bits[11:3]), 12'(e.word));
        check({e.name, ".alu"},  12'(bits[2:0]),  12'(e.alu));
        check({e.name, ".illegal"}, 12'(illegal_op), 12'(e.ill));
        check({e.name, ".we_excl"}, 12'(bits[11] & bits[7]), 12'd0);
      end
    end
  end

  task automatic apply(input string nm, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic [8:0] w,
                       input logic [2:0] a, input logic ill);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n = rst;
    opcode  = op;
    funct   = fn;
    zero    = z;
    e.name  = nm;
    e.word  = w;
    e.alu   = a;
    e.ill   = ill;
    sb_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0;
    opcode  = 6'h23;
    funct   = 6'h00;
    zero    = 1'b0;

    apply("reset",    1'b0, 6'h23, 6'h00, 1'b0, 9'b1_00_1_0_01_00, A_ADD, 1'b0);
    apply("lw",       1'b1, 6'h23, 6'h15, 1'b1, 9'b1_00_1_0_01_00, A_ADD, 1'b0);
    apply("sw",       1'b1, 6'h2B, 6'h00, 1'b0, 9'b0_00_1_1_00_00, A_ADD, 1'b0);
    apply("addi",     1'b1, 6'h08, 6'h22, 1'b1, 9'b1_00_1_0_00_00, A_ADD, 1'b0);
    apply("j",        1'b1, 6'h02, 6'h00, 1'b0, 9'b0_00_0_0_00_10, A_ADD, 1'b0);
    apply("jal",      1'b1, 6'h03, 6'h2A, 1'b0, 9'b1_10_0_0_10_10, A_ADD, 1'b0);
    apply("beq_nt",   1'b1, 6'h04, 6'h00, 1'b0, 9'b0_00_0_0_00_00, A_SUB, 1'b0);
    apply("beq_t",    1'b1, 6'h04, 6'h24, 1'b1, 9'b0_00_0_0_00_01, A_SUB, 1'b0);
    apply("r_add",    1'b1, 6'h00, 6'h20, 1'b0, 9'b1_01_0_0_00_00, A_ADD, 1'b0);
    apply("r_sub",    1'b1, 6'h00, 6'h22, 1'b1, 9'b1_01_0_0_00_00, A_SUB, 1'b0);
    apply("r_and",    1'b1, 6'h00, 6'h24, 1'b0, 9'b1_01_0_0_00_00, A_AND, 1'b0);
    apply("r_or",     1'b1, 6'h00, 6'h25, 1'b0, 9'b1_01_0_0_00_00, A_OR,  1'b0);
    apply("r_slt",    1'b1, 6'h00, 6'h2A, 1'b0, 9'b1_01_0_0_00_00, A_SLT, 1'b0);
    apply("jr",       1'b1, 6'h00, 6'h08, 1'b1, 9'b0_00_0_0_00_11, A_ADD, 1'b0);
    // Bad opcode for one cycle; the flag shows up only after the next edge.
    apply("bad_op",   1'b1, 6'h3F, 6'h20, 1'b1, 9'b0_00_0_0_00_00, A_ADD, 1'b0);
    apply("sticky1",  1'b1, 6'h23, 6'h00, 1'b0, 9'b1_00_1_0_01_00, A_ADD, 1'b1);
    apply("sticky2",  1'b1, 6'h00, 6'h25, 1'b0, 9'b1_01_0_0_00_00, A_OR,  1'b1);
    apply("rst_mid",  1'b0, 6'h04, 6'h00, 1'b1, 9'b0_00_0_0_00_01, A_SUB, 1'b0);
    apply("post_rst", 1'b1, 6'h2B, 6'h00, 1'b0, 9'b0_00_1_1_00_00, A_ADD, 1'b0);
    // Unsupported R-type funct also sets the flag.
    apply("bad_fn",   1'b1, 6'h00, 6'h01, 1'b0, 9'b0_00_0_0_00_00, A_ADD, 1'b0);
    apply("sticky3",  1'b1, 6'h08, 6'h00, 1'b0, 9'b1_00_1_0_00_00, A_ADD, 1'b1);
    apply("rst_end",  1'b0, 6'h02, 6'h00, 1'b0, 9'b0_00_0_0_00_10, A_ADD, 1'b0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clock);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
